// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pkg
//  Brief    : Shared defaults, beat types and elaboration helpers for the
//             AXI-Stream elastic buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package axis_pkg;

    localparam int c_DEF_WORD_W = 8;
    localparam int c_DEF_BUS_W  = 8;
    localparam int c_DEF_DEPTH  = 4;
    localparam int c_DEF_WPB    = c_DEF_BUS_W / c_DEF_WORD_W;

    // Beat layout for the default configuration; the buffer rebuilds the
    // same shape locally from its own parameters.
    typedef logic [c_DEF_WPB-1:0][c_DEF_WORD_W-1:0] beat_t;
    typedef struct packed {
        logic  last;
        beat_t data;
    } axis_beat_t;

    // True when n is a power of two no smaller than two.
    function automatic bit is_pow2_ge2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_buf_mem.sv
`default_nettype none
// ============================================================================
//  Module   : axis_buf_mem
//  Brief    : DEPTH-entry flop array, one synchronous write port and one
//             asynchronous read port. Storage is deliberately not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_buf_mem #(
    parameter  int DEPTH   = 4,
    parameter  int ENTRY_W = 9,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Write the incoming beat into its slot on the accepting edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/axis_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_elastic_buffer
//  Brief    : DEPTH-entry AXI-Stream elastic buffer with tlast, fill count
//             and synchronous flush. s_ready / m_valid come from registers
//             (only flush gates them combinationally).
//  Revision : 1.0 - initial release
// ============================================================================
module axis_elastic_buffer
    import axis_pkg::*;
#(
    parameter  int WORD_W = c_DEF_WORD_W,
    parameter  int BUS_W  = c_DEF_BUS_W,
    parameter  int DEPTH  = c_DEF_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BUS_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BUS_W-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] count
);

    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_WPB     = BUS_W / WORD_W;
    localparam int c_ENTRY_W = BUS_W + 1;

    typedef struct packed {
        logic                          last;
        logic [c_WPB-1:0][WORD_W-1:0]  data;
    } entry_t;

    generate
        if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
            $error("axis_elastic_buffer: DEPTH must be a power of two >= 2");
        end
        if ((BUS_W % WORD_W) != 0) begin : g_bad_bus
            $error("axis_elastic_buffer: BUS_W must be a multiple of WORD_W");
        end
    endgenerate

    logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rst_done_q, rst_done_d;
    logic             w_push, w_pop;
    entry_t           w_wr_entry, w_rd_entry;

    // Handshake flags are registered state qualified only by flush, so no
    // combinational path exists from m_ready to s_ready or s_valid to m_valid.
    assign s_ready = rst_done_q & (count_q != CNT_W'(DEPTH)) & ~flush;
    assign m_valid = (count_q != '0) & ~flush;
    assign w_push  = s_valid & s_ready;
    assign w_pop   = m_valid & m_ready;

    assign w_wr_entry.last = s_last;
    assign w_wr_entry.data = s_data;

    // Outputs are forced to zero while reset is held; otherwise the head slot.
    assign m_data = rstn ? w_rd_entry.data : '0;
    assign m_last = rstn ? w_rd_entry.last : 1'b0;
    assign count  = count_q;

    // Next-state for pointers and fill count; flush overrides every handshake.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rst_done_d = 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rst_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rst_done_q <= rst_done_d;
        end
    end

    axis_buf_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (c_ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (wr_ptr_q),
        .wdata (w_wr_entry),
        .raddr (rd_ptr_q),
        .rdata (w_rd_entry)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_elastic_buffer
//  Brief    : Directed self-checking bench for axis_elastic_buffer (DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_elastic_buffer;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    axis_elastic_buffer #(
        .WORD_W (8),
        .BUS_W  (8),
        .DEPTH  (4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream stability watch: a stalled beat must stay put until accepted.
    logic       pend_q = 1'b0;
    logic [7:0] hold_q = '0;
    always @(posedge clk) begin
        if (pend_q && rstn && !flush && (s_valid !== 1'b1 || s_data !== hold_q)) begin
            bad = bad + 1;
            $display("FAIL axis_hold: s_valid=%b s_data=%h required held %h", s_valid, s_data, hold_q);
        end
        pend_q <= rstn & s_valid & ~s_ready & ~flush;
        hold_q <= s_data;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_valid = 1'b1;
        s_data  = 8'h77;
        repeat (3) cyc();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        s_valid = 1'b0;
        rstn    = 1'b1;
        cyc();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_s_ready: got %b want 1", s_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rel_count: got %0d want 0", count); end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = vals[i];
            cyc();
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", count); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_s_ready: got %b want 0", s_ready); end
        s_data = 8'h55;
        repeat (2) cyc();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_hold_count: got %0d want 4", count); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL fill_m_valid: got %b want 1", m_valid); end
        total++; if (m_data !== 8'h11) begin bad++; $display("FAIL fill_m_data: got %h want 11", m_data); end
    endtask

    task automatic test_drain();
        logic [7:0] exp_q [$];
        logic       did_pop, did_push;
        logic [7:0] pv;
        int         npop;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h5B};
        npop = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            did_pop  = m_valid & m_ready;
            did_push = s_valid & s_ready;
            pv       = m_data;
            cyc();
            total++;
            if (!did_pop) begin
                bad++; $display("FAIL drain_rate: cycle %0d m_valid got 0 want 1", i);
            end else begin
                if (pv !== exp_q[npop]) begin bad++; $display("FAIL drain_data: got %h want %h", pv, exp_q[npop]); end
                npop++;
            end
            if (did_push) s_data = s_data + 8'h01;
            total++; if (count < 3'd3 || count > 3'd4) begin bad++; $display("FAIL drain_count: got %0d want 3..4", count); end
        end
        s_valid = 1'b0;
        for (int i = 0; i < 10 && m_valid; i++) begin
            pv = m_data;
            cyc();
            total++;
            if (npop >= 11) begin bad++; $display("FAIL drain_extra: got beat %h want none", pv); end
            else if (pv !== exp_q[npop]) begin bad++; $display("FAIL drain_tail: got %h want %h", pv, exp_q[npop]); end
            npop++;
        end
        total++; if (npop != 11) begin bad++; $display("FAIL drain_total: got %0d want 11", npop); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_empty: got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        int         idx, rx;
        logic       did_pop, did_push, pl;
        logic [7:0] pv;
        idx = 0; rx = 0;
        s_valid = 1'b1; s_data = 8'h00; s_last = 1'b0;
        m_ready = 1'b0;
        for (int c = 0; c < 200 && rx < 20; c++) begin
            did_pop  = m_valid & m_ready;
            did_push = s_valid & s_ready;
            pv = m_data; pl = m_last;
            cyc();
            if (did_pop) begin
                total++;
                if (pv !== 8'(rx) || pl !== (rx == 19)) begin
                    bad++; $display("FAIL wrap_beat: got %h/%b want %h/%b", pv, pl, 8'(rx), (rx == 19));
                end
                rx++;
            end
            if (did_push) begin
                idx++;
                if (idx < 20) begin s_data = 8'(idx); s_last = (idx == 19); end
                else begin s_valid = 1'b0; s_last = 1'b0; end
            end
            m_ready = ~m_ready;
        end
        m_ready = 1'b0;
        total++; if (rx != 20) begin bad++; $display("FAIL wrap_count: got %0d beats want 20", rx); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = 8'hA1; cyc();
        s_data = 8'hA2; cyc();
        s_data = 8'hA3; cyc();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre: got %0d want 3", count); end
        s_data = 8'hB0;
        m_ready = 1'b1;
        flush = 1'b1;
        #1;
        total++; if (s_ready !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL flush_hs: got %b/%b want 0/0", s_ready, m_valid); end
        cyc();
        flush = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_m_valid: got %b want 0", m_valid); end
        s_valid = 1'b1; s_data = 8'hAA; cyc();
        s_valid = 1'b0;
        total++; if (m_valid !== 1'b1 || m_data !== 8'hAA) begin bad++; $display("FAIL flush_next: got %b/%h want 1/aa", m_valid, m_data); end
        m_ready = 1'b1; cyc();
        m_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_pop: got %0d want 0", count); end
    endtask

    task automatic test_simul_reset();
        logic [7:0] pv;
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hC1; s_last = 1'b0; cyc();
        s_data = 8'hC2; m_ready = 1'b1;
        pv = m_data;
        cyc();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL simul_count: got %0d want 1", count); end
        total++; if (pv !== 8'hC1 || m_data !== 8'hC2) begin bad++; $display("FAIL simul_data: got %h/%h want c1/c2", pv, m_data); end
        m_ready = 1'b0;
        s_data = 8'hC3; cyc();
        s_data = 8'hC4;
        #2 rstn = 1'b0;
        #1;
        total++; if (count !== 3'd0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL midrst: got cnt=%0d mv=%b sr=%b want 0/0/0", count, m_valid, s_ready);
        end
        repeat (2) cyc();
        rstn = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL abort_leak: got m_data %h want no beat", m_data); end
        end
        s_valid = 1'b1; s_data = 8'hD0; s_last = 1'b1; m_ready = 1'b0; cyc();
        s_valid = 1'b0; s_last = 1'b0;
        total++; if (m_valid !== 1'b1 || m_data !== 8'hD0 || m_last !== 1'b1) begin
            bad++; $display("FAIL post_rst_beat: got %b/%h/%b want 1/d0/1", m_valid, m_data, m_last);
        end
        m_ready = 1'b1; cyc();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL post_rst_pop: got %0d want 0", count); end
    endtask

    initial begin
        rstn = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        #2 rstn = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_simul_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
